// File: rtl/digit_entry_if.sv
// Valid/ready handshake carrying the committed 32-bit word from the entry
// block (master) to the consuming CPU-side logic (slave).
interface digit_entry_if;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/digit_entry.sv
// Hex word entry from switches and three push buttons. Each button is
// synchronised, debounced and turned into a single-cycle press pulse; a small
// FSM edits the word digit by digit and offers it over a valid/ready handshake.
module digit_entry #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sw_nibble_i,
    input  logic        btn_enter_i,
    input  logic        btn_clear_i,
    input  logic        btn_commit_i,
    output logic [31:0] edit_buf_o,
    output logic [2:0]  cursor_o,
    digit_entry_if.master out_if
);

    typedef enum logic [0:0] {
        ST_EDIT  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    localparam int CH_ENTER  = 0;
    localparam int CH_CLEAR  = 1;
    localparam int CH_COMMIT = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       btn_raw_s;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       db_q;
    logic [2:0]       db_dly_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [2:0]       pulse_s;

    state_t           state_q;
    logic [31:0]      edit_buf_q;
    logic [2:0]       cursor_q;
    logic [31:0]      data_q;
    logic             valid_q;
    logic [31:0]      edit_buf_d;
    logic [2:0]       cursor_d;

    assign btn_raw_s = {btn_commit_i, btn_clear_i, btn_enter_i};

    // Synchronise raw buttons and accept a new level only after it has been stable long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 3'b000;
            sync2_q  <= 3'b000;
            db_q     <= 3'b000;
            db_dly_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_q  <= btn_raw_s;
            sync2_q  <= sync1_q;
            db_dly_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= {CNT_W{1'b0}};
                end else if (cnt_q[i] == CNT_LAST) begin
                    db_q[i]  <= sync2_q[i];
                    cnt_q[i] <= {CNT_W{1'b0}};
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // One pulse per accepted press: rising edge of the debounced level.
    assign pulse_s = db_q & ~db_dly_q;

    // Apply this cycle's clear/enter to the edit word; clear wins over enter.
    always_comb begin
        edit_buf_d = edit_buf_q;
        cursor_d   = cursor_q;
        if (pulse_s[CH_CLEAR]) begin
            edit_buf_d = 32'h0000_0000;
            cursor_d   = 3'd0;
        end else if (pulse_s[CH_ENTER]) begin
            edit_buf_d[{cursor_q, 2'b00} +: 4] = sw_nibble_i;
            cursor_d                           = cursor_q + 3'd1;
        end else begin
            edit_buf_d = edit_buf_q;
            cursor_d   = cursor_q;
        end
    end

    // Edit/offer FSM; a commit captures the already-updated word, offers freeze all edits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EDIT;
            edit_buf_q <= 32'h0000_0000;
            cursor_q   <= 3'd0;
            data_q     <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_EDIT: begin
                    edit_buf_q <= edit_buf_d;
                    cursor_q   <= cursor_d;
                    if (pulse_s[CH_COMMIT]) begin
                        data_q  <= edit_buf_d;
                        valid_q <= 1'b1;
                        state_q <= ST_OFFER;
                    end else begin
                        valid_q <= 1'b0;
                        state_q <= ST_EDIT;
                    end
                end
                ST_OFFER: begin
                    if (out_if.ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_EDIT;
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= ST_OFFER;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_EDIT;
                end
            endcase
        end
    end

    assign edit_buf_o   = edit_buf_q;
    assign cursor_o     = cursor_q;
    assign out_if.data  = data_q;
    assign out_if.valid = valid_q;

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry with a short debounce. Directed scenarios followed by
// random button sequences, all checked against a digit-array model.
module tb_digit_entry;

    localparam int DB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_nibble;
    logic       btn_enter;
    logic       btn_clear;
    logic       btn_commit;
    logic [31:0] edit_buf;
    logic [2:0]  cursor;

    digit_entry_if bus ();

    digit_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_nibble_i  (sw_nibble),
        .btn_enter_i  (btn_enter),
        .btn_clear_i  (btn_clear),
        .btn_commit_i (btn_commit),
        .edit_buf_o   (edit_buf),
        .cursor_o     (cursor),
        .out_if       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: eight hex digits, a cursor, and the offered word.
    logic [3:0]  m_dig [8];
    int          m_cur;
    logic [31:0] m_data;
    logic        m_offer;

    function automatic logic [31:0] m_word();
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < 8; k++) w = w | (32'(m_dig[k]) << (4 * k));
        return w;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 8; k++) m_dig[k] = 4'h0;
        m_cur   = 0;
        m_data  = 32'h0;
        m_offer = 1'b0;
    endtask

    task automatic m_apply(input logic e, input logic c, input logic m, input logic [3:0] nib);
        if (!m_offer) begin
            if (c) begin
                for (int k = 0; k < 8; k++) m_dig[k] = 4'h0;
                m_cur = 0;
            end else if (e) begin
                m_dig[m_cur] = nib;
                m_cur = (m_cur + 1) % 8;
            end
            if (m) begin
                m_data  = m_word();
                m_offer = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_edit(input string tag);
        check({tag, ".edit_buf"}, edit_buf, m_word());
        check({tag, ".cursor"}, {29'b0, cursor}, 32'(m_cur));
        check({tag, ".valid"}, {31'b0, bus.valid}, {31'b0, m_offer});
    endtask

    // Hold the chosen buttons long enough to be accepted, release, let it settle.
    task automatic press(input logic e, input logic c, input logic m, input logic [3:0] nib);
        @(negedge clk);
        sw_nibble  = nib;
        btn_enter  = e;
        btn_clear  = c;
        btn_commit = m;
        repeat (10) @(negedge clk);
        btn_enter  = 1'b0;
        btn_clear  = 1'b0;
        btn_commit = 1'b0;
        repeat (10) @(negedge clk);
        m_apply(e, c, m, nib);
    endtask

    task automatic accept_offer(input string tag);
        @(negedge clk);
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".drop"}, {31'b0, bus.valid}, 32'd0);
        bus.ready = 1'b0;
        m_offer = 1'b0;
    endtask

    int vcnt;
    logic [31:0] vdata;
    logic [31:0] held;

    initial begin
        rst_n      = 1'b0;
        sw_nibble  = 4'h0;
        btn_enter  = 1'b0;
        btn_clear  = 1'b0;
        btn_commit = 1'b0;
        bus.ready  = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check_edit("reset");
        check("reset.data", bus.data, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Short glitch below the debounce threshold does nothing.
        sw_nibble = 4'h5;
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        check_edit("glitch");

        // Long press: action lands exactly after edge DB+3.
        sw_nibble = 4'hA;
        btn_enter = 1'b1;
        repeat (DB + 2) @(posedge clk);
        #1;
        check("latency.before", {29'b0, cursor}, 32'd0);
        @(posedge clk);
        #1;
        check("latency.at", {29'b0, cursor}, 32'd1);
        check("latency.buf", edit_buf, 32'h0000000A);
        repeat (13) @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        m_apply(1'b1, 1'b0, 1'b0, 4'hA);
        check_edit("hold_once");

        // Entry of 1..8 then 9 wraps and overwrites digit 0.
        press(1'b0, 1'b1, 1'b0, 4'h0);
        for (int d = 1; d <= 9; d++) press(1'b1, 1'b0, 1'b0, 4'(d));
        check_edit("wrap");
        check("wrap.const", edit_buf, 32'h87654329);

        // Clear and enter together: clear wins.
        press(1'b1, 1'b1, 1'b0, 4'h7);
        check_edit("clr_ent");
        check("clr_ent.const", edit_buf, 32'h0);

        // Build DEADBEEF, commit with ready low, offer must hold.
        begin
            logic [31:0] w;
            w = 32'hDEADBEEF;
            for (int k = 0; k < 8; k++) press(1'b1, 1'b0, 1'b0, w[4*k +: 4]);
        end
        check("deadbeef", edit_buf, 32'hDEADBEEF);
        press(1'b0, 1'b0, 1'b1, 4'h0);
        check_edit("offer");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("offer.hold", bus.data, 32'hDEADBEEF);
            check("offer.valid", {31'b0, bus.valid}, 32'd1);
        end
        press(1'b1, 1'b0, 1'b0, 4'h3);
        press(1'b0, 1'b1, 1'b0, 4'h3);
        check_edit("offer.ignore");
        check("offer.data", bus.data, 32'hDEADBEEF);
        accept_offer("hs");

        // Asynchronous reset in the middle of an offer.
        press(1'b0, 1'b0, 1'b1, 4'h0);
        check("rst.pre", {31'b0, bus.valid}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.valid", {31'b0, bus.valid}, 32'd0);
        check("rst.data", bus.data, 32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_edit("rst.release");
        press(1'b1, 1'b0, 1'b0, 4'hC);
        check_edit("rst.edit");

        // Ready tied high: exactly one cycle of valid carrying the word.
        bus.ready = 1'b1;
        @(negedge clk);
        btn_commit = 1'b1;
        vcnt  = 0;
        vdata = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) btn_commit = 1'b0;
            if (bus.valid) begin
                vcnt++;
                vdata = bus.data;
            end
        end
        check("tied.count", 32'(vcnt), 32'd1);
        check("tied.data", vdata, m_word());
        bus.ready = 1'b0;
        repeat (5) @(negedge clk);

        // Random sequences including same-cycle commit+enter.
        for (int it = 0; it < 30; it++) begin
            int act;
            logic [3:0] nib;
            act = int'($urandom_range(0, 9));
            nib = 4'($urandom_range(0, 15));
            if (act <= 5)      press(1'b1, 1'b0, 1'b0, nib);
            else if (act == 6) press(1'b0, 1'b1, 1'b0, nib);
            else if (act == 7) press(1'b1, 1'b1, 1'b0, nib);
            else if (act == 8) press(1'b0, 1'b0, 1'b1, nib);
            else               press(1'b1, 1'b0, 1'b1, nib);
            check_edit("rand");
            if (m_offer) begin
                check("rand.data", bus.data, m_data);
                held = m_word();
                press(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
                check("rand.frozen", edit_buf, held);
                check("rand.data2", bus.data, m_data);
                accept_offer("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
